// File: rtl/ofm_wb_pkg.sv
// rtl/ofm_wb_pkg.sv - shared types and constants for the OFM write-back path
package ofm_wb_pkg;

  localparam int DEF_NUM_PE = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_WORD_W = 64;
  localparam int DEF_ADDR_W = 7;

  localparam int BYTES_PER_WORD = DEF_WORD_W / DEF_DATA_W;

  typedef logic [$clog2(DEF_NUM_PE)-1:0] lane_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WR_LO   = 3'd2,
    ST_WR_HI   = 3'd3,
    ST_DONE    = 3'd4
  } wb_state_t;

endpackage

// File: rtl/ofm_capture_reg.sv
// rtl/ofm_capture_reg.sv - per-lane byte latches with a sticky valid mask
module ofm_capture_reg #(
  parameter int NUM_PE = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [NUM_PE-1:0]        PE_finish,
  input  logic [NUM_PE*DATA_W-1:0] OFM_in,
  output logic [NUM_PE*DATA_W-1:0] bytes,
  output logic                     all_valid
);

  logic [NUM_PE-1:0]        mask_q, mask_d;
  logic [NUM_PE*DATA_W-1:0] bytes_q, bytes_d;

  // A repeated strobe simply overwrites its lane, so the last byte wins.
  always_comb begin
    bytes_d = bytes_q;
    mask_d  = mask_q | PE_finish;
    for (int i = 0; i < NUM_PE; i++) begin
      if (PE_finish[i]) begin
        bytes_d[i*DATA_W +: DATA_W] = OFM_in[i*DATA_W +: DATA_W];
      end
    end
    if (clear) begin
      mask_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    mask_q  <= mask_d;
    bytes_q <= bytes_d;
  end

  assign bytes     = bytes_q;
  assign all_valid = &(mask_q | PE_finish);

endmodule

// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - packs 16 PE output bytes into two 64-bit OFM BRAM writes per pixel
module ofm_writeback #(
  parameter int NUM_PE = 16,
  parameter int DATA_W = 8,
  parameter int WORD_W = 64,
  parameter int ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-2:0]        num_pixels,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [NUM_PE-1:0]        PE_finish,
  input  logic [NUM_PE*DATA_W-1:0] OFM_in,
  output logic                     we,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WORD_W-1:0]        data_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic                     wrap
);

  import ofm_wb_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  wb_state_t           state_q, state_d;
  logic [ADDR_W-2:0]   num_q, num_d;
  logic [ADDR_W-2:0]   pix_q, pix_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                overrun_q, overrun_d;
  logic                wrap_q, wrap_d;

  logic                     collecting;
  logic [NUM_PE-1:0]        cap_strobe;
  logic                     cap_clear;
  logic [NUM_PE*DATA_W-1:0] cap_bytes;
  logic                     all_valid;
  logic                     last_pixel;

  assign collecting = (state_q == ST_COLLECT);
  // Strobes outside COLLECT are dropped here so they can never reach the latches.
  assign cap_strobe = PE_finish & {NUM_PE{collecting}};
  assign cap_clear  = reset | (state_q == ST_WR_HI);
  assign last_pixel = (({1'b0, pix_q} + ADDR_W'(1)) == {1'b0, num_q});

  ofm_capture_reg #(
    .NUM_PE (NUM_PE),
    .DATA_W (DATA_W)
  ) u_capture (
    .clk       (clk),
    .clear     (cap_clear),
    .PE_finish (cap_strobe),
    .OFM_in    (OFM_in),
    .bytes     (cap_bytes),
    .all_valid (all_valid)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    pix_d     = pix_q;
    addr_d    = addr_q;
    overrun_d = overrun_q;
    wrap_d    = wrap_q;

    if (!collecting && (|PE_finish)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_pixels;
          addr_d    = base_addr;
          pix_d     = '0;
          overrun_d = 1'b0;
          wrap_d    = 1'b0;
          state_d   = (num_pixels == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (all_valid) begin
          state_d = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        // The high word goes to addr+1, which wraps when the low word sits at the top.
        if (addr_q == ADDR_MAX) begin
          wrap_d = 1'b1;
        end
        state_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        if (addr_q >= (ADDR_MAX - ADDR_W'(1))) begin
          wrap_d = 1'b1;
        end
        addr_d  = addr_q + ADDR_W'(2);
        pix_d   = pix_q + (ADDR_W-1)'(1);
        state_d = last_pixel ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      pix_q     <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      pix_q     <= pix_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    we       = 1'b0;
    wr_addr  = '0;
    data_out = '0;
    case (state_q)
      ST_WR_LO: begin
        we       = 1'b1;
        wr_addr  = addr_q;
        data_out = cap_bytes[WORD_W-1:0];
      end
      ST_WR_HI: begin
        we       = 1'b1;
        wr_addr  = addr_q + ADDR_W'(1);
        data_out = cap_bytes[2*WORD_W-1:WORD_W];
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign overrun = overrun_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// tb/tb_ofm_writeback.sv - self-checking bench for ofm_writeback
module tb_ofm_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   num_pixels;
  logic [6:0]   base_addr;
  logic [15:0]  PE_finish;
  logic [127:0] OFM_in;
  logic         we;
  logic [6:0]   wr_addr;
  logic [63:0]  data_out;
  logic         busy;
  logic         done;
  logic         overrun;
  logic         wrap;

  always #5 clk = ~clk;

  ofm_writeback dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_pixels (num_pixels),
    .base_addr  (base_addr),
    .PE_finish  (PE_finish),
    .OFM_in     (OFM_in),
    .we         (we),
    .wr_addr    (wr_addr),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .wrap       (wrap)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observed BRAM writes and done pulses, sampled on the falling edge.
  typedef logic [70:0] wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  done_cnt = 0;
  int  d0 = 0;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) done_cnt++;
      if (we === 1'b1) obs_q.push_back({wr_addr, data_out});
      else check("idle_bus", {57'd0, wr_addr, data_out}, 128'd0);
    end
  end

  // Reference model: lane bytes, which lanes have arrived, and the expected writes.
  logic [7:0]  m_bytes[16];
  logic [15:0] m_mask;
  int          m_pix;
  logic [6:0]  m_base;

  task automatic strobe(input logic [15:0] pe, input logic [127:0] ofm, output bit complete);
    logic [63:0] lo, hi;
    logic [6:0]  a;
    @(posedge clk);
    #1;
    PE_finish = pe;
    OFM_in    = ofm;
    for (int i = 0; i < 16; i++) if (pe[i]) m_bytes[i] = ofm[8*i +: 8];
    m_mask   = m_mask | pe;
    complete = (m_mask == 16'hFFFF);
    if (complete) begin
      for (int j = 0; j < 8; j++) begin
        lo[8*j +: 8] = m_bytes[j];
        hi[8*j +: 8] = m_bytes[j+8];
      end
      a = 7'((int'(m_base) + 2 * m_pix) % 128);
      exp_q.push_back({a, lo});
      exp_q.push_back({7'(a + 7'd1), hi});
      m_mask = '0;
      m_pix++;
    end
  endtask

  // Fills the WR_LO and WR_HI cycles; optionally fires a stray lane-3 strobe during WR_LO.
  task automatic gap(input bit stray);
    @(posedge clk);
    #1;
    if (stray) begin
      PE_finish = 16'h0008;
      OFM_in    = {96'd0, 32'h00EE_0000};
      OFM_in[31:24] = 8'hEE;
    end else begin
      PE_finish = '0;
    end
    @(posedge clk);
    #1;
    PE_finish = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start_run(input int num, input logic [6:0] base);
    obs_q.delete();
    exp_q.delete();
    m_base = base;
    m_pix  = 0;
    m_mask = '0;
    d0     = done_cnt;
    @(posedge clk);
    #1;
    start      = 1'b1;
    num_pixels = 6'(num);
    base_addr  = base;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic rand_pixel();
    bit c = 1'b0;
    int it = 0;
    while (!c) begin
      strobe((it >= 6) ? 16'hFFFF : 16'($urandom()), rnd128(), c);
      it++;
    end
    gap(1'b0);
  endtask

  task automatic all_pixel();
    bit c;
    strobe(16'hFFFF, rnd128(), c);
    gap(1'b0);
  endtask

  task automatic stagger_pixel(input string name);
    bit c;
    for (int l = 15; l >= 0; l--) begin
      if (l == 0) check({name, "_nowrite"}, obs_q.size(), 2 * m_pix);
      strobe(16'(1) << l, rnd128(), c);
    end
    gap(1'b0);
  endtask

  task automatic finish_run(input string name, input bit exp_wrap, input bit exp_ovr);
    int t = 0;
    while (done_cnt == d0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_cnt"}, done_cnt - d0, 1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", name, i), (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
    check({name, "_wrap"}, wrap, exp_wrap);
    check({name, "_overrun"}, overrun, exp_ovr);
  endtask

  typedef struct {
    int         num;
    logic [6:0] base;
    int         mode;      // 0 all lanes at once, 1 staggered 15..0, 2 random
    bit         exp_wrap;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] ofm;
    bit c;

    vt[0] = '{2, 7'h00, 1, 1'b0};
    vt[1] = '{1, 7'h7F, 0, 1'b1};
    vt[2] = '{3, 7'h7E, 2, 1'b1};
    vt[3] = '{4, 7'h20, 2, 1'b0};
    vt[4] = '{2, 7'h7D, 2, 1'b1};
    vt[5] = '{5, 7'h3A, 2, 1'b0};

    reset = 1'b1; start = 1'b0; num_pixels = '0; base_addr = '0;
    PE_finish = '0; OFM_in = '0; m_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check("rst_outs", {we, wr_addr, data_out, busy, done, overrun, wrap}, '0);

    // Single pixel, all lanes at once, bytes i+1: exact words and latency.
    start_run(1, 7'h10);
    check("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 16; i++) ofm[8*i +: 8] = 8'(i + 1);
    strobe(16'hFFFF, ofm, c);
    @(posedge clk);
    #1;
    PE_finish = '0;
    @(negedge clk);
    check("p1_lo", {we, wr_addr, data_out}, {1'b1, 7'h10, 64'h0807060504030201});
    @(negedge clk);
    check("p1_hi", {we, wr_addr, data_out}, {1'b1, 7'h11, 64'h100F0E0D0C0B0A09});
    @(negedge clk);
    check("p1_done", {done, we}, 2'b10);
    @(negedge clk);
    check("p1_after", {done, busy, overrun, wrap}, 4'b0000);

    for (int v = 0; v < 6; v++) begin
      start_run(vt[v].num, vt[v].base);
      for (int p = 0; p < vt[v].num; p++) begin
        case (vt[v].mode)
          0:       all_pixel();
          1:       stagger_pixel($sformatf("v%0d", v));
          default: rand_pixel();
        endcase
      end
      finish_run($sformatf("vec%0d", v), vt[v].exp_wrap, 1'b0);
    end

    // Stray strobe during WR_LO, plus an ignored start while busy.
    start_run(2, 7'h40);
    strobe(16'hFFFF, rnd128(), c);
    gap(1'b1);
    start = 1'b1; num_pixels = 6'd5; base_addr = 7'h00;
    strobe(16'hFFF7, rnd128(), c);
    strobe(16'h0008, rnd128(), c);
    start = 1'b0;
    gap(1'b0);
    finish_run("ovr", 1'b0, 1'b1);

    // Zero-pixel run: clears overrun, done in the cycle after start is taken, no writes.
    start_run(0, 7'h11);
    check("zero_ovr_clr", overrun, 1'b0);
    check("zero_done", {done, we}, 2'b10);
    finish_run("zero", 1'b0, 1'b0);

    // Reset sampled at the end of WR_LO: WR_HI never happens.
    start_run(1, 7'h30);
    strobe(16'hFFFF, rnd128(), c);
    @(posedge clk);
    #1;
    PE_finish = '0;
    check("rst_wrlo", {we, wr_addr}, {1'b1, 7'h30});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_outs", {we, wr_addr, data_out, busy, done, overrun, wrap}, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_nwr", obs_q.size(), 1);
    m_mask = '0;
    start_run(1, 7'h31);
    rand_pixel();
    finish_run("post_rst", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
